// File: rtl/fr_rule_scheduler.sv
// Steps one input frame through every fuzzy rule on the shared processing element.
// Define FR_SUM_EN to add the fs_sum port, which carries the per-frame firing-strength total.
module fr_rule_scheduler #(
    parameter int unsigned NUM_RULES = 16,
    parameter int unsigned IDX_W     = 4,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_valid,
    output logic              frame_ready,
    output logic [IDX_W-1:0]  rule_idx,
    output logic              param_rd_en,
    output logic              pe_start,
    input  logic              pe_ready,
    input  logic [DATA_W-1:0] pe_out,
    output logic              fs_valid,
    output logic [IDX_W-1:0]  fs_idx,
    output logic [6:0]        fs_data,
    output logic              frame_done,
    output logic              busy,
    output logic              err_timeout
`ifdef FR_SUM_EN
    ,
    output logic [7+IDX_W-1:0] fs_sum
`endif
);

    localparam int unsigned CNT_W = 8;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_RULES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAUNCH,
        S_WAIT,
        S_STORE,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_capture;
    logic             w_timeout;
    logic [CNT_W-1:0] r_cnt;
    logic             w_unused_pe;

    // Only the low 7 bits of the PE result carry the firing strength.
    assign w_unused_pe = ^pe_out[DATA_W-1:7];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (frame_valid) begin
                    w_state_nxt = S_FETCH;
                    w_accept    = 1'b1;
                end
            end
            S_FETCH:  w_state_nxt = S_LAUNCH;
            S_LAUNCH: w_state_nxt = S_WAIT;
            S_WAIT: begin
                // A result arriving on the final allowed cycle still counts.
                if (pe_ready) begin
                    w_state_nxt = S_STORE;
                    w_capture   = 1'b1;
                end else if (r_cnt == TIMEOUT_CNT) begin
                    w_state_nxt = S_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            S_STORE:  w_state_nxt = (rule_idx == LAST_IDX) ? S_DONE : S_FETCH;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered decodes of the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_ready <= 1'b1;
            busy        <= 1'b0;
            param_rd_en <= 1'b0;
            pe_start    <= 1'b0;
            frame_done  <= 1'b0;
            fs_valid    <= 1'b0;
            fs_idx      <= '0;
            fs_data     <= '0;
            rule_idx    <= '0;
            err_timeout <= 1'b0;
            r_cnt       <= '0;
        end else begin
            frame_ready <= (w_state_nxt == S_IDLE);
            busy        <= (w_state_nxt != S_IDLE);
            param_rd_en <= (w_state_nxt == S_FETCH);
            pe_start    <= (w_state_nxt == S_LAUNCH);
            frame_done  <= (w_state_nxt == S_DONE);
            fs_valid    <= w_capture;

            if (w_capture) begin
                fs_idx  <= rule_idx;
                fs_data <= pe_out[6:0];
            end

            if (w_accept) begin
                rule_idx    <= '0;
                err_timeout <= 1'b0;
            end else if ((r_state == S_STORE) && (w_state_nxt == S_FETCH)) begin
                rule_idx <= rule_idx + IDX_W'(1);
            end

            if (w_timeout) begin
                err_timeout <= 1'b1;
            end

            // Counter reads k in the k-th WAIT cycle.
            if (w_state_nxt == S_LAUNCH) begin
                r_cnt <= '0;
            end else if ((r_state == S_LAUNCH) || (r_state == S_WAIT)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

`ifdef FR_SUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fs_sum <= '0;
        end else if (w_accept) begin
            fs_sum <= '0;
        end else if (w_capture) begin
            fs_sum <= fs_sum + (7 + IDX_W)'(pe_out[6:0]);
        end
    end
`endif

endmodule
